modexp_ctrl: RTL and testbench

- Left-to-right square-and-multiply modular exponentiation controller: result = x^e mod M.
- Acts as the initiator for the Montgomery multiplier. It issues operand/start requests on a port-level handshake and consumes the multiplier's result and done.
- Sits between the software-facing register/DMA interface and the Montgomery multiplier instance.
- Montgomery constant is R = 2^WIDTH. R mod M and R^2 mod M are precomputed by software and supplied as inputs.

---
 rtl/modexp_pkg.sv | 19 +
 rtl/modexp_ctrl_if.sv | 25 ++
 rtl/exp_bit_scanner.sv | 47 ++++
 rtl/modexp_ctrl.sv | 174 +++++++++++++++++
 tb/tb_modexp_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/modexp_pkg.sv
// Shared types and defaults for the modular exponentiation controller.
package modexp_pkg;

    localparam int unsigned MODEXP_WIDTH   = 1024;
    localparam int unsigned MODEXP_E_WIDTH = 1024;
    localparam int unsigned MODEXP_ELEN_W  = 11;

    localparam logic [MODEXP_WIDTH-1:0] ONE = MODEXP_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE,
        TO_MONT,
        SQUARE,
        MULT,
        FROM_MONT,
        DONE
    } state_e;

endpackage

// File: rtl/modexp_ctrl_if.sv
// Operand/start request and result/done return path to the Montgomery multiplier.
interface modexp_ctrl_if
    import modexp_pkg::*;
#(
    parameter int unsigned WIDTH = MODEXP_WIDTH
) ();

    logic             mm_start;
    logic [WIDTH-1:0] mm_a;
    logic [WIDTH-1:0] mm_b;
    logic [WIDTH-1:0] mm_m;
    logic [WIDTH-1:0] mm_result;
    logic             mm_done;

    modport master (
        output mm_start, mm_a, mm_b, mm_m,
        input  mm_result, mm_done
    );

    modport slave (
        input  mm_start, mm_a, mm_b, mm_m,
        output mm_result, mm_done
    );

endinterface

// File: rtl/exp_bit_scanner.sv
// Presents exponent bits MSB-first (from bit e_len-1 down to 0), one per step pulse.
module exp_bit_scanner #(
    parameter int unsigned E_WIDTH = 1024,
    parameter int unsigned ELEN_W  = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic [E_WIDTH-1:0] e_i,
    input  logic [ELEN_W-1:0]  e_len_i,
    input  logic               step_i,
    output logic               cur_bit_o,
    output logic               last_bit_o,
    output logic               empty_o
);

    logic [E_WIDTH-1:0] bits_q;
    logic [ELEN_W-1:0]  left_q;
    logic               last_q;
    logic               empty_q;

    // Left-align the significant bits so the current bit is always the MSB;
    // bits at or above e_len fall off the top.
    always_ff @(posedge clk) begin
        if (reset) begin
            bits_q  <= '0;
            left_q  <= '0;
            last_q  <= 1'b0;
            empty_q <= 1'b1;
        end else if (load_i) begin
            bits_q  <= e_i << (ELEN_W'(E_WIDTH) - e_len_i);
            left_q  <= e_len_i;
            last_q  <= (e_len_i == ELEN_W'(1));
            empty_q <= (e_len_i == '0);
        end else if (step_i && (left_q != '0)) begin
            bits_q  <= bits_q << 1;
            left_q  <= left_q - ELEN_W'(1);
            last_q  <= (left_q == ELEN_W'(2));
            empty_q <= (left_q == ELEN_W'(1));
        end
    end

    assign cur_bit_o  = bits_q[E_WIDTH-1];
    assign last_bit_o = last_q;
    assign empty_o    = empty_q;

endmodule

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply x^e mod M, sequencing a Montgomery multiplier
// through TO_MONT, SQUARE/MULT per exponent bit, then FROM_MONT.
module modexp_ctrl
    import modexp_pkg::*;
#(
    parameter int unsigned WIDTH   = MODEXP_WIDTH,
    parameter int unsigned E_WIDTH = MODEXP_E_WIDTH,
    parameter int unsigned ELEN_W  = MODEXP_ELEN_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   in_x,
    input  logic [E_WIDTH-1:0] in_e,
    input  logic [ELEN_W-1:0]  in_e_len,
    input  logic [WIDTH-1:0]   in_m,
    input  logic [WIDTH-1:0]   in_r,
    input  logic [WIDTH-1:0]   in_r2,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    modexp_ctrl_if.master      mm
);

    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(ONE);

    state_e           state_q;
    logic             wait_q;
    logic             busy_q;
    logic             done_q;
    logic             mm_start_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] mm_a_q;
    logic [WIDTH-1:0] mm_b_q;
    logic [WIDTH-1:0] mm_m_q;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] xt_q;

    logic             cur_bit;
    logic             last_bit;
    logic             e_empty;

    logic             load_c;
    logic             complete_c;
    logic             step_c;
    state_e           nxt_state_c;
    logic [WIDTH-1:0] nxt_a_c;
    logic [WIDTH-1:0] nxt_b_c;

    assign load_c     = (state_q == IDLE) && start;
    assign complete_c = wait_q && mm.mm_done &&
                        (state_q inside {TO_MONT, SQUARE, MULT, FROM_MONT});

    exp_bit_scanner #(
        .E_WIDTH (E_WIDTH),
        .ELEN_W  (ELEN_W)
    ) u_scan (
        .clk        (clk),
        .reset      (reset),
        .load_i     (load_c),
        .e_i        (in_e),
        .e_len_i    (in_e_len),
        .step_i     (step_c),
        .cur_bit_o  (cur_bit),
        .last_bit_o (last_bit),
        .empty_o    (e_empty)
    );

    // Next multiplication to issue once the current one completes; the
    // accumulator lives in mm_a_q and is refreshed straight from mm_result.
    always_comb begin
        nxt_state_c = FROM_MONT;
        nxt_a_c     = mm.mm_result;
        nxt_b_c     = ONE_W;
        step_c      = 1'b0;
        case (state_q)
            TO_MONT: begin
                nxt_a_c = r_q;
                if (!e_empty) begin
                    nxt_state_c = SQUARE;
                    nxt_b_c     = r_q;
                end
            end
            SQUARE: begin
                if (cur_bit) begin
                    nxt_state_c = MULT;
                    nxt_b_c     = xt_q;
                end else begin
                    step_c = complete_c;
                    if (!last_bit) begin
                        nxt_state_c = SQUARE;
                        nxt_b_c     = mm.mm_result;
                    end
                end
            end
            MULT: begin
                step_c = complete_c;
                if (!last_bit) begin
                    nxt_state_c = SQUARE;
                    nxt_b_c     = mm.mm_result;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wait_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mm_start_q <= 1'b0;
            result_q   <= '0;
            mm_a_q     <= '0;
            mm_b_q     <= '0;
            mm_m_q     <= '0;
            r_q        <= '0;
            xt_q       <= '0;
        end else begin
            done_q     <= 1'b0;
            mm_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        r_q        <= in_r;
                        mm_m_q     <= in_m;
                        mm_a_q     <= in_x;
                        mm_b_q     <= in_r2;
                        mm_start_q <= 1'b1;
                        wait_q     <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= TO_MONT;
                    end
                end
                TO_MONT, SQUARE, MULT, FROM_MONT: begin
                    // wait_q low marks the ISSUE cycle (mm_start visible)
                    if (!wait_q) begin
                        wait_q <= 1'b1;
                    end else if (mm.mm_done) begin
                        wait_q <= 1'b0;
                        if (state_q == TO_MONT) begin
                            xt_q <= mm.mm_result;
                        end
                        if (state_q == FROM_MONT) begin
                            result_q <= mm.mm_result;
                            state_q  <= DONE;
                        end else begin
                            state_q    <= nxt_state_c;
                            mm_a_q     <= nxt_a_c;
                            mm_b_q     <= nxt_b_c;
                            mm_start_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;
    assign mm.mm_start = mm_start_q;
    assign mm.mm_a     = mm_a_q;
    assign mm.mm_b     = mm_b_q;
    assign mm.mm_m     = mm_m_q;

endmodule

// File: tb/tb_modexp_ctrl.sv
// Scoreboard bench: a behavioural Montgomery multiplier answers the DUT, and a
// plain-arithmetic right-to-left exponentiation supplies the expected results.
module tb_modexp_ctrl;

    localparam int unsigned W   = 1024;
    localparam int unsigned EW  = 1024;
    localparam int unsigned ELW = 11;

    typedef struct {
        logic [W-1:0] res;
        int           n_mm;
        string        tag;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [W-1:0]   in_x;
    logic [EW-1:0]  in_e;
    logic [ELW-1:0] in_e_len;
    logic [W-1:0]   in_m;
    logic [W-1:0]   in_r;
    logic [W-1:0]   in_r2;
    logic           busy;
    logic           done;
    logic [W-1:0]   result;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   mm_cnt   = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    modexp_ctrl_if #(.WIDTH(W)) mmif ();

    modexp_ctrl #(
        .WIDTH   (W),
        .E_WIDTH (EW),
        .ELEN_W  (ELW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_x     (in_x),
        .in_e     (in_e),
        .in_e_len (in_e_len),
        .in_m     (in_m),
        .in_r     (in_r),
        .in_r2    (in_r2),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .mm       (mmif)
    );

    // a * b * 2^-W mod m, bit-serial reduction, fully reduced
    function automatic logic [W-1:0] montmul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] m);
        logic [W+1:0] t;
        t = '0;
        for (int i = 0; i < int'(W); i++) begin
            if (a[i]) t = t + {2'b00, b};
            if (t[0]) t = t + {2'b00, m};
            t = t >> 1;
        end
        if (t >= {2'b00, m}) t = t - {2'b00, m};
        return t[W-1:0];
    endfunction

    function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] m);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        p = p % {{W{1'b0}}, m};
        return p[W-1:0];
    endfunction

    function automatic logic [W-1:0] golden(input logic [W-1:0] x, input logic [EW-1:0] e,
                                            input int elen, input logic [W-1:0] m);
        logic [W-1:0] r;
        logic [W-1:0] base;
        r    = W'(1) % m;
        base = x % m;
        for (int i = 0; i < elen; i++) begin
            if (e[i]) r = mulmod(r, base, m);
            base = mulmod(base, base, m);
        end
        return r;
    endfunction

    function automatic int popcnt(input logic [EW-1:0] e, input int elen);
        int n;
        n = 0;
        for (int i = 0; i < elen; i++) if (e[i]) n++;
        return n;
    endfunction

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] v;
        for (int i = 0; i < int'(W / 32); i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act[127:0], req[127:0]);
        end
    endtask

    // Multiplier slave: random latency 1..4 cycles, garbage on mm_result when idle
    initial begin : mult_model
        int           lat;
        logic [W-1:0] pend;
        lat = 0;
        pend = '0;
        mmif.mm_done   = 1'b0;
        mmif.mm_result = '0;
        forever begin
            @(posedge clk);
            #2;
            mmif.mm_done   = 1'b0;
            mmif.mm_result = rand_w();
            if (lat > 0) begin
                lat--;
                if (lat == 0) begin
                    mmif.mm_result = pend;
                    mmif.mm_done   = 1'b1;
                end
            end
            if (mmif.mm_start) begin
                pend = montmul(mmif.mm_a, mmif.mm_b, mmif.mm_m);
                lat  = int'($urandom_range(1, 4));
            end
        end
    end

    // Monitor: pops the scoreboard on done, checks pulse counts and operand stability
    initial begin : monitor
        logic [W-1:0] ca, cb, cm;
        bit           in_wait, stable, done_prev;
        exp_t         item;
        in_wait   = 1'b0;
        stable    = 1'b1;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                in_wait   = 1'b0;
                done_prev = 1'b0;
                continue;
            end
            if (done_prev) begin
                check("done_one_cycle", W'(done), W'(0));
                check("busy_low_after_done", W'(busy), W'(0));
            end
            done_prev = done;
            if (mmif.mm_start) begin
                mm_cnt++;
                ca = mmif.mm_a;
                cb = mmif.mm_b;
                cm = mmif.mm_m;
                in_wait = 1'b1;
                stable  = 1'b1;
            end else if (in_wait) begin
                if (mmif.mm_a !== ca || mmif.mm_b !== cb || mmif.mm_m !== cm) stable = 1'b0;
                if (mmif.mm_done) begin
                    check("operands_stable_in_wait", W'(stable), W'(1));
                    in_wait = 1'b0;
                end
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", W'(1), W'(0));
                end else begin
                    item = exp_q.pop_front();
                    check({item.tag, "_result"}, result, item.res);
                    check({item.tag, "_mm_start_count"}, W'(mm_cnt), W'(item.n_mm));
                end
                mm_cnt = 0;
            end
        end
    end

    task automatic start_op(input string tag, input logic [W-1:0] x, input logic [EW-1:0] e,
                            input int elen, input logic [W-1:0] m, input bit push);
        logic [W:0]   rr;
        logic [W-1:0] rmod;
        exp_t         item;
        rr       = {1'b1, {W{1'b0}}} % {1'b0, m};
        rmod     = rr[W-1:0];
        in_x     = x;
        in_e     = e;
        in_e_len = ELW'(elen);
        in_m     = m;
        in_r     = rmod;
        in_r2    = mulmod(rmod, rmod, m);
        if (push) begin
            item.res  = golden(x, e, elen, m);
            item.n_mm = 2 + elen + popcnt(e, elen);
            item.tag  = tag;
            exp_q.push_back(item);
        end
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) begin
            check({tag, "_busy_t1"}, W'(busy), W'(1));
            check({tag, "_mm_start_t1"}, W'(mmif.mm_start), W'(1));
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: %0d ops outstanding after %0d cycles, required 0",
                     tag, exp_q.size(), budget);
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [W-1:0]  m, x;
        logic [EW-1:0] e;
        int            n, elen;
        bit            saw_done;
        reset = 1'b1;
        start = 1'b0;
        in_x = '0; in_e = '0; in_e_len = '0; in_m = '0; in_r = '0; in_r2 = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_busy", W'(busy), W'(0));
        check("reset_done", W'(done), W'(0));
        check("reset_mm_start", W'(mmif.mm_start), W'(0));
        check("reset_result", result, W'(0));
        check("reset_mm_a", mmif.mm_a, W'(0));
        check("reset_mm_b", mmif.mm_b, W'(0));
        check("reset_mm_m", mmif.mm_m, W'(0));

        start_op("x3e5", W'(3), EW'(5), 3, W'(13), 1'b1);
        wait_idle("x3e5", 500);
        check("x3e5_result_held", result, W'(9));

        start_op("elen0", W'(7), EW'(0), 0, W'(13), 1'b1);
        wait_idle("elen0", 500);
        check("elen0_result_held", result, W'(1));

        start_op("x0", W'(0), EW'(8'hFF), 8, W'(32'h10001), 1'b1);
        wait_idle("x0", 1000);
        check("x0_result_held", result, W'(0));
        check("x0_busy_idle", W'(busy), W'(0));

        // Upper exponent bits beyond e_len must be ignored; second start is dropped
        start_op("busy_start", W'(5), EW'(8'hF3), 4, W'(97), 1'b1);
        repeat (4) @(posedge clk);
        #1;
        start_op("ignored", W'(11), EW'(8'h7F), 7, W'(101), 1'b0);
        wait_idle("busy_start", 1000);
        check("busy_start_result_held", result, W'(28));

        // Abort during the third multiplication's wait phase
        start_op("aborted", W'(10), EW'(8'hAB), 8, W'(1009), 1'b1);
        n = 0;
        while (mm_cnt < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached_third_issue", W'(mm_cnt >= 3), W'(1));
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        mm_cnt = 0;
        check("abort_busy", W'(busy), W'(0));
        check("abort_mm_start", W'(mmif.mm_start), W'(0));
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", W'(saw_done), W'(0));
        start_op("after_abort", W'(10), EW'(8'hAB), 8, W'(1009), 1'b1);
        wait_idle("after_abort", 1000);

        for (int k = 0; k < 2; k++) begin
            m = rand_w();
            m[0] = 1'b1;
            m[W-1] = 1'b1;
            x = rand_w() % m;
            e = rand_w();
            start_op($sformatf("rand_full%0d", k), x, e, int'(EW), m, 1'b1);
            wait_idle($sformatf("rand_full%0d", k), 20000);
        end

        for (int k = 0; k < 3; k++) begin
            m = rand_w();
            m[0] = 1'b1;
            x = rand_w() % m;
            e = rand_w();
            elen = int'($urandom_range(1, 40));
            start_op($sformatf("rand_short%0d", k), x, e, elen, m, 1'b1);
            wait_idle($sformatf("rand_short%0d", k), 2000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
